// File: rtl/mult8x8_pkg.sv
// Shared types and constants for the 8x8 multiplier controller.
// Optional feature macro used by the scheduler: MULT_ZERO_SKIP_EN.
package mult8x8_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PP0  = 3'd1,
      ST_PP1  = 3'd2,
      ST_PP2  = 3'd3,
      ST_PP3  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [1:0] SHIFT_0 = 2'b00;
   localparam logic [1:0] SHIFT_4 = 2'b01;
   localparam logic [1:0] SHIFT_8 = 2'b10;

endpackage

// File: rtl/mult8x8_sched.sv
// Partial-product scheduler: picks the next PP state (or DONE) after the given state.
// With MULT_ZERO_SKIP_EN defined, PP states with a zero A or B nibble are skipped.
module mult8x8_sched
   import mult8x8_pkg::*;
(
   input  state_t     state,
   input  logic [3:0] nib_zero,
   output state_t     next_state
);

   logic [3:0] run;
   int         first_idx;

`ifdef MULT_ZERO_SKIP_EN
   logic [3:0] skip;

   // nib_zero bits: [0]=A lo, [1]=A hi, [2]=B lo, [3]=B hi
   always_comb begin
      skip[0] = nib_zero[0] | nib_zero[2];
      skip[1] = nib_zero[0] | nib_zero[3];
      skip[2] = nib_zero[1] | nib_zero[2];
      skip[3] = nib_zero[1] | nib_zero[3];
      run     = ~skip;
   end
`else
   logic unused_nib_zero;

   assign unused_nib_zero = ^nib_zero;
   assign run             = 4'hF;
`endif

   always_comb begin
      first_idx = 0;
      case (state)
         ST_PP0:  first_idx = 1;
         ST_PP1:  first_idx = 2;
         ST_PP2:  first_idx = 3;
         ST_PP3:  first_idx = 4;
         default: first_idx = 0;
      endcase

      // Descending scan so the lowest runnable PP index at or after first_idx wins.
      next_state = ST_DONE;
      for (int i = 3; i >= 0; i--) begin
         if (i >= first_idx && run[i]) begin
            next_state = state_t'(3'(i + 1));
         end
      end
   end

endmodule

// File: rtl/mult8x8_ctrl.sv
// Sequencing controller for an 8x8 multiply built from a shared 4x4 multiplier and shifter.
// Optional zero-nibble skipping is enabled with MULT_ZERO_SKIP_EN (see mult8x8_sched).
module mult8x8_ctrl
   import mult8x8_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [2*NIBBLE_W-1:0] dataa,
   input  logic [2*NIBBLE_W-1:0] datab,
   output logic [NIBBLE_W-1:0]   mult_a,
   output logic [NIBBLE_W-1:0]   mult_b,
   output logic [1:0]            shift_ctrl,
   input  logic [15:0]           shift_out,
   output logic [15:0]           product,
   output logic                  busy,
   output logic                  done
);

   state_t                state_q, state_d, sched_next;
   logic [2*NIBBLE_W-1:0] a_q, a_d, b_q, b_d;
   logic [15:0]           acc_q, acc_d;
   logic                  accepting;
   logic [2*NIBBLE_W-1:0] src_a, src_b;
   logic [3:0]            nib_zero;

   assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // On a start the schedule must be chosen from the incoming operands, not the stale ones.
   assign src_a    = accepting ? dataa : a_q;
   assign src_b    = accepting ? datab : b_q;
   assign nib_zero = {src_b[2*NIBBLE_W-1:NIBBLE_W] == '0, src_b[NIBBLE_W-1:0] == '0,
                      src_a[2*NIBBLE_W-1:NIBBLE_W] == '0, src_a[NIBBLE_W-1:0] == '0};

   mult8x8_sched u_sched (
      .state      (state_q),
      .nib_zero   (nib_zero),
      .next_state (sched_next)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = dataa;
               b_d     = datab;
               acc_d   = '0;
               state_d = sched_next;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
            acc_d   = acc_q + shift_out;
            state_d = sched_next;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
      end
   end

   always_comb begin
      mult_a     = '0;
      mult_b     = '0;
      shift_ctrl = SHIFT_0;
      case (state_q)
         ST_PP0: begin
            mult_a = a_q[NIBBLE_W-1:0];
            mult_b = b_q[NIBBLE_W-1:0];
         end
         ST_PP1: begin
            mult_a     = a_q[NIBBLE_W-1:0];
            mult_b     = b_q[2*NIBBLE_W-1:NIBBLE_W];
            shift_ctrl = SHIFT_4;
         end
         ST_PP2: begin
            mult_a     = a_q[2*NIBBLE_W-1:NIBBLE_W];
            mult_b     = b_q[NIBBLE_W-1:0];
            shift_ctrl = SHIFT_4;
         end
         ST_PP3: begin
            mult_a     = a_q[2*NIBBLE_W-1:NIBBLE_W];
            mult_b     = b_q[2*NIBBLE_W-1:NIBBLE_W];
            shift_ctrl = SHIFT_8;
         end
         default: ;
      endcase
   end

   assign busy    = (state_q == ST_PP0) || (state_q == ST_PP1) ||
                    (state_q == ST_PP2) || (state_q == ST_PP3);
   assign done    = (state_q == ST_DONE);
   assign product = acc_q;

endmodule
